// File: rtl/raster_ctrl_pkg.sv
// Shared types for the raster sequencer.
// State encodings and sticky error bit positions.
package raster_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACTIVE    = 2'd1,
    ST_WAIT_LINE = 2'd2
  } state_t;

  localparam int ERR_STRAY      = 0;
  localparam int ERR_SHORT_LINE = 1;
  localparam int ERR_ABORT      = 2;

endpackage

// File: rtl/raster_counter.sv
// Column/row position counters for the raster sequencer.
// A clear and an increment in the same cycle yield 1.
module raster_counter #(
  parameter  int width  = 640,
  parameter  int height = 480,
  localparam int CW     = $clog2(width),
  localparam int RW     = $clog2(height)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_col,
  input  logic          inc_col,
  input  logic          clr_row,
  input  logic          inc_row,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_col,
  output logic          last_row
);

  assign last_col = (col == CW'(width - 1));
  assign last_row = (row == RW'(height - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= (clr_col ? '0 : col) + CW'(inc_col);
      row <= (clr_row ? '0 : row) + RW'(inc_row);
    end
  end

endmodule

// File: rtl/raster_ctrl.sv
// Raster sequencer: frame/line tracking, shift gating,
// 3x3 window-centre tagging and sticky timing errors.
module raster_ctrl
  import raster_ctrl_pkg::*;
#(
  parameter  int width  = 640,
  parameter  int height = 480,
  localparam int CW     = $clog2(width),
  localparam int RW     = $clog2(height)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          err_clr,
  output logic          shift_en,
  output logic          pix_valid,
  output logic          win_valid,
  output logic [CW-1:0] cx,
  output logic [RW-1:0] cy,
  output logic          line_done,
  output logic          frame_done,
  output logic [2:0]    err,
  output logic [1:0]    state
);

  state_t          st, nst;
  logic [CW-1:0]   col, pc;
  logic [RW-1:0]   row, pr;
  logic            last_col, last_row;
  logic            clr_col, inc_col;
  logic            clr_row, inc_row;
  logic            acc, ld, fd;
  logic [2:0]      eset;

  raster_counter #(
    .width  (width),
    .height (height)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr_col  (clr_col),
    .inc_col  (inc_col),
    .clr_row  (clr_row),
    .inc_row  (inc_row),
    .col      (col),
    .row      (row),
    .last_col (last_col),
    .last_row (last_row)
  );

  // pc/pr hold the coordinates of the pixel accepted this cycle
  always_comb begin
    nst     = st;
    acc     = 1'b0;
    clr_col = 1'b0;
    inc_col = 1'b0;
    clr_row = 1'b0;
    inc_row = 1'b0;
    pc      = col;
    pr      = row;
    ld      = 1'b0;
    fd      = 1'b0;
    eset    = '0;
    if (vsync) begin
      eset[ERR_ABORT] = (st != ST_IDLE);
      nst     = ST_ACTIVE;
      clr_col = 1'b1;
      clr_row = 1'b1;
      acc     = en;
      inc_col = en;
      pc      = '0;
      pr      = '0;
    end else begin
      unique case (st)
        ST_ACTIVE: begin
          if (hsync && col != '0) begin
            eset[ERR_SHORT_LINE] = 1'b1;
            clr_col = 1'b1;
            if (last_row) begin
              nst     = ST_IDLE;
              clr_row = 1'b1;
            end else begin
              inc_row = 1'b1;
              acc     = en;
              inc_col = en;
              pc      = '0;
              pr      = row + RW'(1);
            end
          end else if (en) begin
            acc = 1'b1;
            if (last_col) begin
              ld      = 1'b1;
              clr_col = 1'b1;
              if (last_row) begin
                fd      = 1'b1;
                clr_row = 1'b1;
                nst     = ST_IDLE;
              end else begin
                inc_row = 1'b1;
                nst     = ST_WAIT_LINE;
              end
            end else begin
              inc_col = 1'b1;
            end
          end
        end
        ST_WAIT_LINE: begin
          if (hsync) begin
            nst     = ST_ACTIVE;
            clr_col = 1'b1;
            acc     = en;
            inc_col = en;
            pc      = '0;
          end else if (en) begin
            eset[ERR_STRAY] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign shift_en = acc & ~reset;
  assign state    = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= ST_IDLE;
      pix_valid  <= 1'b0;
      win_valid  <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      err        <= '0;
    end else begin
      st         <= nst;
      pix_valid  <= acc;
      win_valid  <= acc && pc >= CW'(2) && pr >= RW'(2);
      line_done  <= ld;
      frame_done <= fd;
      err        <= (err_clr ? 3'b000 : err) | eset;
      if (acc) begin
        cx <= pc - CW'(1);
        cy <= pr - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_raster_ctrl.sv
// Self-checking bench for raster_ctrl (4x3 frame).
// Directed test-plan scenarios plus randomized traffic.
module tb_raster_ctrl;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk = 1'b0;
  logic          reset, en, hsync, vsync, err_clr;
  logic          shift_en, pix_valid, win_valid;
  logic [CW-1:0] cx;
  logic [RW-1:0] cy;
  logic          line_done, frame_done;
  logic [2:0]    err;
  logic [1:0]    state;

  raster_ctrl #(.width(W), .height(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .hsync      (hsync),
    .vsync      (vsync),
    .err_clr    (err_clr),
    .shift_en   (shift_en),
    .pix_valid  (pix_valid),
    .win_valid  (win_valid),
    .cx         (cx),
    .cy         (cy),
    .line_done  (line_done),
    .frame_done (frame_done),
    .err        (err),
    .state      (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model: mode 0 idle, 1 inside a line, 2 between lines
  int   m_mode, mr, mc;
  logic [2:0] merr;
  int   e_pv, e_wv, e_ld, e_fd, e_cx, e_cy;
  bit   cx_def, cy_def;

  // observation counters for literal checks
  int n_shift, n_ld, n_fd, n_win;
  int wcx[4], wcy[4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  task automatic clr_obs();
    n_shift = 0; n_ld = 0; n_fd = 0; n_win = 0;
  endtask

  task automatic step(input bit r, input bit e, input bit h,
                      input bit v, input bit c);
    int  nm, nr, nc, pc, pr;
    bit  acc, ld, fd;
    logic [2:0] es;
    reset = r; en = e; hsync = h; vsync = v; err_clr = c;
    #1;
    acc = 0; ld = 0; fd = 0; es = '0;
    nm = m_mode; nr = mr; nc = mc; pc = 0; pr = 0;
    if (v) begin
      if (m_mode != 0) es[2] = 1'b1;
      nm = 1; nr = 0; nc = 0;
      if (e) begin acc = 1; pc = 0; pr = 0; nc = 1; end
    end else if (m_mode == 2) begin
      if (h) begin
        nm = 1; nc = 0;
        if (e) begin acc = 1; pc = 0; pr = mr; nc = 1; end
      end else if (e) es[0] = 1'b1;
    end else if (m_mode == 1) begin
      if (h && mc != 0) begin
        es[1] = 1'b1; nc = 0;
        if (mr < H - 1) begin
          nr = mr + 1;
          if (e) begin acc = 1; pc = 0; pr = nr; nc = 1; end
        end else begin
          nm = 0; nr = 0;
        end
      end else if (e) begin
        acc = 1; pc = mc; pr = mr;
        if (mc == W - 1) begin
          ld = 1; nc = 0;
          if (mr == H - 1) begin fd = 1; nm = 0; nr = 0; end
          else begin nr = mr + 1; nm = 2; end
        end else nc = mc + 1;
      end
    end
    if (r) acc = 0;
    chk("shift_en", shift_en, acc);
    if (shift_en) n_shift++;
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0; mr = 0; mc = 0; merr = '0;
      e_pv = 0; e_wv = 0; e_ld = 0; e_fd = 0;
      chk("reset_cx", cx, 0);
      chk("reset_cy", cy, 0);
    end else begin
      m_mode = nm; mr = nr; mc = nc;
      merr = (c ? 3'b000 : merr) | es;
      e_pv = acc; e_ld = ld; e_fd = fd;
      e_wv = (acc && pc >= 2 && pr >= 2);
      if (acc) begin
        e_cx = (pc - 1) & ((1 << CW) - 1);
        e_cy = (pr - 1) & ((1 << RW) - 1);
        cx_def = (pc >= 1);
        cy_def = (pr >= 1);
      end
    end
    chk("pix_valid", pix_valid, e_pv);
    chk("win_valid", win_valid, e_wv);
    chk("line_done", line_done, e_ld);
    chk("frame_done", frame_done, e_fd);
    chk("err", err, merr);
    chk("state", state, m_mode);
    if (!r && e_pv && cx_def) chk("cx", cx, e_cx);
    if (!r && e_pv && cy_def) chk("cy", cy, e_cy);
    if (line_done) n_ld++;
    if (frame_done) n_fd++;
    if (win_valid) begin
      if (n_win < 4) begin wcx[n_win] = cx; wcy[n_win] = cy; end
      n_win++;
    end
    @(negedge clk);
  endtask

  task automatic px(input bit e);
    step(0, e, 0, 0, 0);
  endtask

  initial begin
    m_mode = 0; mr = 0; mc = 0; merr = '0;
    e_pv = 0; e_wv = 0; e_ld = 0; e_fd = 0; e_cx = 0; e_cy = 0;
    cx_def = 0; cy_def = 0;
    clr_obs();

    // reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    chk("rst_state", state, 0);
    chk("rst_err", err, 0);

    // full 4x3 frame, hsync at pixels 5 and 9
    clr_obs();
    for (int p = 1; p <= 12; p++)
      step(0, 1, (p == 5 || p == 9), (p == 1), 0);
    chk("frame_done_after_p12", frame_done, 1);
    px(0);
    chk("frame_shift_cnt", n_shift, 12);
    chk("frame_line_done_cnt", n_ld, 3);
    chk("frame_done_cnt", n_fd, 1);
    chk("frame_win_cnt", n_win, 2);
    chk("win0_cx", wcx[0], 1);
    chk("win0_cy", wcy[0], 1);
    chk("win1_cx", wcx[1], 2);
    chk("win1_cy", wcy[1], 1);

    // gapped en inside a line
    step(0, 1, 0, 1, 0);
    px(0); px(1); px(0); px(1);
    chk("gap_cx_col2", cx, 1);
    px(0);
    chk("gap_pv_low", pix_valid, 0);
    px(1);
    chk("gap_line_done", line_done, 1);

    // short line on row 0, then err_clr
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    px(1);
    step(0, 1, 1, 0, 0);
    chk("short_err", err, 3'b010);
    chk("short_cy_row1", cy, 0);
    step(0, 0, 0, 0, 1);
    chk("short_err_clr", err, 0);

    // finish row 1, then stray en in the gap
    px(1); px(1); px(1);
    chk("row1_line_done", line_done, 1);
    clr_obs();
    px(1); px(1); px(1);
    chk("stray_shift_cnt", n_shift, 0);
    chk("stray_err", err, 3'b001);
    step(0, 1, 1, 0, 0);
    chk("stray_row_kept", cy, 1);

    // vsync abort during row 1, then a full frame
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    clr_obs();
    step(0, 1, 0, 1, 0);
    px(1); px(1); px(1);
    step(0, 1, 1, 0, 0);
    px(1);
    step(0, 1, 0, 1, 0);
    chk("abort_err", err, 3'b100);
    chk("abort_no_fd", n_fd, 0);
    px(1); px(1); px(1);
    for (int l = 0; l < 2; l++) begin
      step(0, 1, 1, 0, 0);
      px(1); px(1); px(1);
    end
    chk("abort_then_fd", n_fd, 1);

    // reset mid-row then en without vsync
    step(0, 1, 0, 1, 0);
    px(1); px(1); px(1);
    step(0, 1, 1, 0, 0);
    px(1);
    step(1, 1, 0, 0, 0);
    clr_obs();
    px(1); px(1); px(1);
    chk("rst_mid_state", state, 0);
    chk("rst_mid_shift", n_shift, 0);
    chk("rst_mid_err", err, 0);
    step(0, 1, 0, 1, 0);
    chk("rst_mid_resume", pix_valid, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
